mor1kx_wb_arbiter_marocchino: RTL and testbench

//  Arbitrates the single register-file write-back port among NUM_REQ execution

---
 rtl/mor1kx_wb_arbiter_marocchino.sv | 112 +++++++++++
 tb/tb_mor1kx_wb_arbiter_marocchino.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/mor1kx_wb_arbiter_marocchino.sv
// Write-back port arbiter: grants one ready execution unit per cycle and registers its result into WB.
// Define MOR1KX_WB_ARB_ROUND_ROBIN_EN for round-robin arbitration; otherwise the lowest ready index wins.
module mor1kx_wb_arbiter_marocchino #(
    parameter int OPTION_OPERAND_WIDTH = 32,
    parameter int OPTION_RF_ADDR_WIDTH = 5,
    parameter int NUM_REQ              = 4
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      pipeline_flush_i,
    input  logic                                      padv_wb_i,
    input  logic [NUM_REQ-1:0]                        req_rdy_i,
    input  logic [NUM_REQ-1:0]                        req_rf_wb_i,
    input  logic [NUM_REQ*OPTION_RF_ADDR_WIDTH-1:0]   req_rfd_adr_i,
    input  logic [NUM_REQ*OPTION_OPERAND_WIDTH-1:0]   req_result_i,
    output logic [NUM_REQ-1:0]                        grant_o,
    output logic                                      wb_valid_o,
    output logic                                      wb_rf_wb_o,
    output logic [OPTION_RF_ADDR_WIDTH-1:0]           wb_rfd_adr_o,
    output logic [OPTION_OPERAND_WIDTH-1:0]           wb_result_o,
    output logic [$clog2(NUM_REQ)-1:0]                wb_src_o,
    output logic                                      wb_stall_o
);
    localparam int SW = $clog2(NUM_REQ);
    localparam int AW = OPTION_RF_ADDR_WIDTH;
    localparam int W  = OPTION_OPERAND_WIDTH;

    logic [NUM_REQ-1:0] eligible;
    logic [SW-1:0]      grant_idx;
    logic [AW-1:0]      sel_adr;
    logic [W-1:0]       sel_result;
    logic               sel_rf_wb;
    logic               any_grant;

    assign eligible = (!rst && padv_wb_i && !pipeline_flush_i) ? req_rdy_i : '0;

`ifdef MOR1KX_WB_ARB_ROUND_ROBIN_EN
    logic [SW-1:0] rr_ptr;

    // Search starts at rr_ptr and wraps; first eligible unit in that order wins.
    always_comb begin
        int  idx;
        logic found;
        grant_o = '0;
        found   = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!found && eligible[idx]) begin
                grant_o[idx] = 1'b1;
                found        = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            rr_ptr <= '0;
        else if (any_grant)
            rr_ptr <= (grant_idx == SW'(NUM_REQ - 1)) ? '0 : grant_idx + SW'(1);
    end
`else
    always_comb begin
        logic found;
        grant_o = '0;
        found   = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && eligible[k]) begin
                grant_o[k] = 1'b1;
                found      = 1'b1;
            end
        end
    end
`endif

    assign any_grant  = |grant_o;
    assign wb_stall_o = |(req_rdy_i & ~grant_o) & ~pipeline_flush_i;

    // AND-OR select so data of non-granted units (possibly X) never reaches the outputs.
    always_comb begin
        grant_idx  = '0;
        sel_adr    = '0;
        sel_result = '0;
        sel_rf_wb  = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_o[i]) begin
                grant_idx  = grant_idx  | SW'(i);
                sel_adr    = sel_adr    | req_rfd_adr_i[i*AW +: AW];
                sel_result = sel_result | req_result_i[i*W +: W];
                sel_rf_wb  = sel_rf_wb  | req_rf_wb_i[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wb_valid_o   <= 1'b0;
            wb_rf_wb_o   <= 1'b0;
            wb_rfd_adr_o <= '0;
            wb_result_o  <= '0;
            wb_src_o     <= '0;
        end else begin
            wb_valid_o <= any_grant;
            wb_rf_wb_o <= any_grant & sel_rf_wb;
            if (any_grant) begin
                wb_rfd_adr_o <= sel_adr;
                wb_result_o  <= sel_result;
                wb_src_o     <= grant_idx;
            end
        end
    end
endmodule

// File: tb/tb_mor1kx_wb_arbiter_marocchino.sv
// Bench for the WB arbiter: queue-free reference model checked every cycle plus directed literal checks.
module tb_mor1kx_wb_arbiter_marocchino;
    localparam int N  = 4;
    localparam int AW = 5;
    localparam int W  = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            flush;
    logic            padv;
    logic [N-1:0]    rdy;
    logic [N-1:0]    rf_wb;
    logic [N*AW-1:0] adr;
    logic [N*W-1:0]  res;
    logic [N-1:0]    grant_o;
    logic            wb_valid_o, wb_rf_wb_o, wb_stall_o;
    logic [AW-1:0]   wb_rfd_adr_o;
    logic [W-1:0]    wb_result_o;
    logic [1:0]      wb_src_o;

    int passed = 0;
    int total  = 0;
    bit chk_en = 1'b0;

    mor1kx_wb_arbiter_marocchino #(
        .OPTION_OPERAND_WIDTH(W), .OPTION_RF_ADDR_WIDTH(AW), .NUM_REQ(N)
    ) dut (
        .clk(clk), .rst(rst), .pipeline_flush_i(flush), .padv_wb_i(padv),
        .req_rdy_i(rdy), .req_rf_wb_i(rf_wb), .req_rfd_adr_i(adr), .req_result_i(res),
        .grant_o(grant_o), .wb_valid_o(wb_valid_o), .wb_rf_wb_o(wb_rf_wb_o),
        .wb_rfd_adr_o(wb_rfd_adr_o), .wb_result_o(wb_result_o), .wb_src_o(wb_src_o),
        .wb_stall_o(wb_stall_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model ----------------
    logic          m_valid, m_rf;
    logic [AW-1:0] m_adr;
    logic [W-1:0]  m_res;
    logic [1:0]    m_src;
    int            m_ptr;
    int            exp_g;
    logic [N-1:0]  exp_grant;

    // Winner = first ready unit found walking from 'start' upward with wrap.
    function automatic int pick(input logic [N-1:0] r, input int start);
        for (int k = 0; k < N; k++)
            if (r[(start + k) % N]) return (start + k) % N;
        return -1;
    endfunction

    always_comb begin
        exp_g     = (rst || !padv || flush) ? -1 : pick(rdy, m_ptr);
        exp_grant = (exp_g < 0) ? '0 : N'(1) << exp_g;
    end

    always @(posedge clk) begin
        if (rst) begin
            m_valid <= 1'b0; m_rf <= 1'b0; m_adr <= '0; m_res <= '0; m_src <= '0; m_ptr <= 0;
        end else if (exp_g >= 0) begin
            m_valid <= 1'b1;
            m_rf    <= rf_wb[exp_g];
            m_adr   <= adr[exp_g*AW +: AW];
            m_res   <= res[exp_g*W +: W];
            m_src   <= 2'(exp_g);
`ifdef MOR1KX_WB_ARB_ROUND_ROBIN_EN
            m_ptr   <= (exp_g + 1) % N;
`endif
        end else begin
            m_valid <= 1'b0;
            m_rf    <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("m_grant",  grant_o, exp_grant);
            chk("m_stall",  wb_stall_o, ($countones(rdy) > (exp_g >= 0 ? 1 : 0)) && !flush);
            chk("m_valid",  wb_valid_o, m_valid);
            chk("m_rf_wb",  wb_rf_wb_o, m_rf);
            chk("m_adr",    wb_rfd_adr_o, m_adr);
            chk("m_result", wb_result_o, m_res);
            chk("m_src",    wb_src_o, m_src);
        end
    end

    // ---------------- directed stimulus ----------------
    logic [N-1:0] t6_exp [5];

    initial begin
`ifdef MOR1KX_WB_ARB_ROUND_ROBIN_EN
        t6_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
`else
        t6_exp = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
`endif
        rst = 1'b1; flush = 1'b0; padv = 1'b1; rdy = '1; rf_wb = '1;
        for (int i = 0; i < N; i++) begin
            adr[i*AW +: AW] = AW'(i + 1);
            res[i*W +: W]   = 32'h1000_0000 + i;
        end

        // 1: reset
        cyc();
        chk_en = 1'b1;
        chk("rst_grant", grant_o, 4'b0000);
        chk("rst_valid", wb_valid_o, 1'b0);
        chk("rst_result", wb_result_o, 32'h0);
        cyc();
        chk("rst_adr", wb_rfd_adr_o, 5'd0);
        chk("rst_src", wb_src_o, 2'd0);
        rst = 1'b0; rdy = '0;
        cyc();
        chk("idle_valid", wb_valid_o, 1'b0);

        // 2: single request with data
        adr[2*AW +: AW] = 5'd7; res[2*W +: W] = 32'hDEADBEEF; rdy = 4'b0100;
        #1 chk("t2_grant", grant_o, 4'b0100);
        cyc();
        chk("t2_valid", wb_valid_o, 1'b1);
        chk("t2_rf_wb", wb_rf_wb_o, 1'b1);
        chk("t2_adr", wb_rfd_adr_o, 5'd7);
        chk("t2_result", wb_result_o, 32'hDEADBEEF);
        chk("t2_src", wb_src_o, 2'd2);

        // 3: priority order; unit 3 alone first so a round-robin pointer sits at 0
        rdy = 4'b1000;
        #1 chk("t3_pre", grant_o, 4'b1000);
        cyc(); rdy = 4'b1011;
        #1 chk("t3_g0", grant_o, 4'b0001);
        cyc(); rdy = 4'b1010;
        #1 chk("t3_g1", grant_o, 4'b0010);
        cyc(); rdy = 4'b1000;
        #1 chk("t3_g2", grant_o, 4'b1000);
        cyc(); rdy = 4'b0010;
        #1 chk("t3_ptr2", grant_o, 4'b0010);
        cyc(); rdy = 4'b0011;
        #1 chk("t3_wrap0", grant_o, 4'b0001);
        cyc(); rdy = 4'b0010;
        #1 chk("t3_wrap1", grant_o, 4'b0010);
        cyc(); rdy = '0;

        // 4: flush dominates
        rdy = 4'b0001; flush = 1'b1;
        #1 chk("t4_grant", grant_o, 4'b0000);
        chk("t4_stall", wb_stall_o, 1'b0);
        cyc();
        chk("t4_valid", wb_valid_o, 1'b0);
        chk("t4_rf_wb", wb_rf_wb_o, 1'b0);
        flush = 1'b0;
        #1 chk("t4_after", grant_o, 4'b0001);
        cyc();
        chk("t4_result", wb_result_o, 32'h1000_0000);
        rdy = 4'b0110; padv = 1'b0;

        // 5: padv low holds everything
        for (int k = 0; k < 3; k++) begin
            #1 chk("t5_grant", grant_o, 4'b0000);
            chk("t5_stall", wb_stall_o, 1'b1);
            cyc();
            chk("t5_valid", wb_valid_o, 1'b0);
            chk("t5_hold", wb_result_o, 32'h1000_0000);
        end
        padv = 1'b1;
        #1 chk("t5_resume", grant_o, 4'b0010);
        cyc();
        chk("t5_src", wb_src_o, 2'd1);
        rdy = 4'b1000;

        // 6: all ready, unit 1 does not write the RF
        cyc();
        rf_wb = 4'b1101; rdy = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            #1 chk("t6_grant", grant_o, t6_exp[k]);
            cyc();
            chk("t6_valid", wb_valid_o, 1'b1);
            chk("t6_rf_wb", wb_rf_wb_o, (t6_exp[k] == 4'b0010) ? 1'b0 : 1'b1);
        end
        rdy = '0;
        cyc(); cyc();
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
